// File: rtl/fft_out_frame_sched.sv
// Frame readout controller for FFT results: emits 0xA5 0x5A, then each bin's payload
// bytes through the 4-byte serializer, then an 8-bit checksum of the payload.
module fft_out_frame_sched #(
    parameter int BW = 28,
    parameter int N  = 256,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          ram_rd_en,
    output logic [AW-1:0] ram_addr,
    input  logic [BW-1:0] ram_re_i,
    input  logic [BW-1:0] ram_im_i,
    output logic          ser_en_wr,
    output logic          ser_en_rd,
    output logic [BW-1:0] ser_re,
    output logic [BW-1:0] ser_im,
    input  logic [7:0]    ser_byte_i,
    input  logic          ser_en_i,
    input  logic          ser_done_i,
    input  logic          tx_ready,
    output logic [7:0]    tx_byte,
    output logic          tx_valid,
    output logic          busy,
    output logic          frame_done
);

    typedef enum logic [3:0] {
        IDLE, HDR0, HDR1, RD_REQ, RD_WAIT, LOAD, STREAM, SER_DONE, CKSUM, DONE
    } state_t;

    localparam logic [AW-1:0] LAST_BIN = AW'(N - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] bin_q, bin_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          infl_q, infl_d;
    logic [7:0]    cksum_q, cksum_d;
    logic [BW-1:0] ser_re_q, ser_re_d, ser_im_q, ser_im_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic          tx_valid_q, tx_valid_d;
    logic          wr_q, wr_d, rd_q, rd_d;
    logic          ram_rd_en_q, ram_rd_en_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;
    logic          issue_ok;

    function automatic logic [7:0] cksum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    // Outputs are registered, so the sink has no ready for the cycle right after a
    // byte; holding off while tx_valid_q is high keeps bytes at least one cycle apart.
    assign issue_ok = tx_ready && !infl_q && !tx_valid_q;

    always_comb begin
        state_d      = state_q;
        bin_d        = bin_q;
        cnt_d        = cnt_q;
        infl_d       = infl_q;
        cksum_d      = cksum_q;
        ser_re_d     = ser_re_q;
        ser_im_d     = ser_im_q;
        tx_byte_d    = tx_byte_q;
        ram_addr_d   = ram_addr_q;
        busy_d       = busy_q;
        tx_valid_d   = 1'b0;
        wr_d         = 1'b0;
        rd_d         = 1'b0;
        ram_rd_en_d  = 1'b0;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cksum_d = 8'h00;
                    bin_d   = '0;
                    busy_d  = 1'b1;
                    state_d = HDR0;
                end
            end
            HDR0: begin
                if (issue_ok) begin
                    tx_valid_d = 1'b1;
                    tx_byte_d  = 8'hA5;
                    state_d    = HDR1;
                end
            end
            HDR1: begin
                if (issue_ok) begin
                    tx_valid_d = 1'b1;
                    tx_byte_d  = 8'h5A;
                    state_d    = RD_REQ;
                end
            end
            RD_REQ: begin
                ram_rd_en_d = 1'b1;
                ram_addr_d  = bin_q;
                state_d     = RD_WAIT;
            end
            RD_WAIT: begin
                // RAM data lands the cycle after the strobe has been seen
                if (!ram_rd_en_q) begin
                    ser_re_d = ram_re_i;
                    ser_im_d = ram_im_i;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                if (issue_ok) begin
                    wr_d    = 1'b1;
                    infl_d  = 1'b1;
                    cnt_d   = 3'd0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (ser_en_i && infl_q) begin
                    tx_byte_d  = ser_byte_i;
                    tx_valid_d = 1'b1;
                    cksum_d    = cksum_add(cksum_q, ser_byte_i);
                    infl_d     = 1'b0;
                    cnt_d      = cnt_q + 3'd1;
                end else if (!infl_q && cnt_q == 3'd4) begin
                    // closing advance lets the serializer raise done; it sends no byte
                    rd_d    = 1'b1;
                    state_d = SER_DONE;
                end else if (issue_ok) begin
                    rd_d   = 1'b1;
                    infl_d = 1'b1;
                end
            end
            SER_DONE: begin
                if (ser_done_i) begin
                    if (bin_q == LAST_BIN) begin
                        state_d = CKSUM;
                    end else begin
                        bin_d   = bin_q + AW'(1);
                        state_d = RD_REQ;
                    end
                end
            end
            CKSUM: begin
                if (issue_ok) begin
                    tx_valid_d = 1'b1;
                    tx_byte_d  = cksum_q;
                    state_d    = DONE;
                end
            end
            DONE: begin
                frame_done_d = 1'b1;
                busy_d       = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bin_q        <= '0;
            cnt_q        <= 3'd0;
            infl_q       <= 1'b0;
            cksum_q      <= 8'h00;
            ser_re_q     <= '0;
            ser_im_q     <= '0;
            tx_byte_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            wr_q         <= 1'b0;
            rd_q         <= 1'b0;
            ram_rd_en_q  <= 1'b0;
            ram_addr_q   <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bin_q        <= bin_d;
            cnt_q        <= cnt_d;
            infl_q       <= infl_d;
            cksum_q      <= cksum_d;
            ser_re_q     <= ser_re_d;
            ser_im_q     <= ser_im_d;
            tx_byte_q    <= tx_byte_d;
            tx_valid_q   <= tx_valid_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            ram_rd_en_q  <= ram_rd_en_d;
            ram_addr_q   <= ram_addr_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign ram_rd_en  = ram_rd_en_q;
    assign ram_addr   = ram_addr_q;
    assign ser_en_wr  = wr_q;
    assign ser_en_rd  = rd_q;
    assign ser_re     = ser_re_q;
    assign ser_im     = ser_im_q;
    assign tx_byte    = tx_byte_q;
    assign tx_valid   = tx_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fft_out_frame_sched.sv
// Bench for fft_out_frame_sched: an N=4 and an N=1 instance, each with a RAM, 4-byte
// serializer and byte-sink model; captured frames are compared to a frame built from RAM contents.
module tb_fft_out_frame_sched;
    localparam int BW = 28;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          start[2];
    logic          ram_rd_en[2];
    logic [AW-1:0] ram_addr[2];
    logic [BW-1:0] ram_re[2], ram_im[2];
    logic          ser_en_wr[2], ser_en_rd[2];
    logic [BW-1:0] ser_re[2], ser_im[2];
    logic [7:0]    ser_byte[2];
    logic          ser_en[2], ser_done[2], tx_ready[2];
    logic [7:0]    tx_byte[2];
    logic          tx_valid[2], busy[2], frame_done[2];

    fft_out_frame_sched #(.BW(BW), .N(4), .AW(AW)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start[0]),
        .ram_rd_en(ram_rd_en[0]), .ram_addr(ram_addr[0]),
        .ram_re_i(ram_re[0]), .ram_im_i(ram_im[0]),
        .ser_en_wr(ser_en_wr[0]), .ser_en_rd(ser_en_rd[0]),
        .ser_re(ser_re[0]), .ser_im(ser_im[0]),
        .ser_byte_i(ser_byte[0]), .ser_en_i(ser_en[0]), .ser_done_i(ser_done[0]),
        .tx_ready(tx_ready[0]), .tx_byte(tx_byte[0]), .tx_valid(tx_valid[0]),
        .busy(busy[0]), .frame_done(frame_done[0])
    );

    fft_out_frame_sched #(.BW(BW), .N(1), .AW(AW)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]),
        .ram_rd_en(ram_rd_en[1]), .ram_addr(ram_addr[1]),
        .ram_re_i(ram_re[1]), .ram_im_i(ram_im[1]),
        .ser_en_wr(ser_en_wr[1]), .ser_en_rd(ser_en_rd[1]),
        .ser_re(ser_re[1]), .ser_im(ser_im[1]),
        .ser_byte_i(ser_byte[1]), .ser_en_i(ser_en[1]), .ser_done_i(ser_done[1]),
        .tx_ready(tx_ready[1]), .tx_byte(tx_byte[1]), .tx_valid(tx_valid[1]),
        .busy(busy[1]), .frame_done(frame_done[1])
    );

    // environment state
    logic [BW-1:0] mem_re[2][4], mem_im[2][4];
    logic [BW-1:0] sl_re[2], sl_im[2];
    int            sidx[2], dcnt[2], rcnt[2];
    int            done_dly[2], drop[2];
    logic          m_en[2], loaded[2], inj_en[2], force_low[2];
    logic [7:0]    m_byte[2];

    // observation state
    logic [7:0] got0[$], got1[$], exp_q[$];
    int v_rdy[2] = '{0, 0};
    int v_tv[2] = '{0, 0};
    int v_pulse[2] = '{0, 0};
    int v_stab[2] = '{0, 0};
    int v_early[2] = '{0, 0};
    int fd_cnt[2] = '{0, 0};
    logic prev_tv[2] = '{1'b0, 1'b0};
    logic prev_wr[2] = '{1'b0, 1'b0};
    logic prev_rd[2] = '{1'b0, 1'b0};

    int n_chk = 0;
    int n_pass = 0;

    function automatic logic [7:0] ser_pick(input logic [BW-1:0] re, input logic [BW-1:0] im, input int k);
        case (k)
            0:       return re[15:8];
            1:       return im[15:8];
            2:       return re[23:16];
            default: return im[23:16];
        endcase
    endfunction

    // RAM with 1-cycle read latency, 4-byte serializer, and a sink that drops ready for drop[i] cycles after each byte
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                ram_re[i] <= '0;  ram_im[i] <= '0;
                sl_re[i]  <= '0;  sl_im[i]  <= '0;
                sidx[i]   <= 4;   dcnt[i]   <= 0;  rcnt[i] <= 0;
                m_en[i]   <= 1'b0; m_byte[i] <= 8'h00;
                ser_done[i] <= 1'b0; loaded[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (ram_rd_en[i]) begin
                    ram_re[i] <= mem_re[i][ram_addr[i][1:0]];
                    ram_im[i] <= mem_im[i][ram_addr[i][1:0]];
                end
                m_en[i] <= 1'b0;
                if (ser_en_wr[i]) begin
                    sl_re[i] <= ser_re[i];  sl_im[i] <= ser_im[i];
                    sidx[i] <= 0;  dcnt[i] <= 0;
                    m_en[i] <= 1'b1;
                    m_byte[i] <= ser_pick(ser_re[i], ser_im[i], 0);
                    ser_done[i] <= 1'b0;  loaded[i] <= 1'b1;
                end else if (ser_en_rd[i]) begin
                    if (sidx[i] < 3) begin
                        sidx[i] <= sidx[i] + 1;
                        m_en[i] <= 1'b1;
                        m_byte[i] <= ser_pick(sl_re[i], sl_im[i], sidx[i] + 1);
                    end else if (sidx[i] == 3) begin
                        sidx[i] <= 4;
                        dcnt[i] <= done_dly[i] + 1;
                    end
                end else if (dcnt[i] > 0) begin
                    dcnt[i] <= dcnt[i] - 1;
                    if (dcnt[i] == 1) ser_done[i] <= 1'b1;
                end
                if (tx_valid[i]) rcnt[i] <= drop[i];
                else if (rcnt[i] > 0) rcnt[i] <= rcnt[i] - 1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            ser_en[i]   = m_en[i] | inj_en[i];
            ser_byte[i] = inj_en[i] ? 8'hEE : m_byte[i];
            tx_ready[i] = !force_low[i] && (rcnt[i] == 0);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_valid[0]) got0.push_back(tx_byte[0]);
            if (tx_valid[1]) got1.push_back(tx_byte[1]);
            for (int i = 0; i < 2; i++) begin
                if (tx_valid[i] && !tx_ready[i]) v_rdy[i] <= v_rdy[i] + 1;
                if (tx_valid[i] && prev_tv[i]) v_tv[i] <= v_tv[i] + 1;
                if ((ser_en_wr[i] && ser_en_rd[i]) || (ser_en_wr[i] && prev_wr[i]) ||
                    (ser_en_rd[i] && prev_rd[i]))
                    v_pulse[i] <= v_pulse[i] + 1;
                if (loaded[i] && !ser_done[i] && (ser_re[i] !== sl_re[i] || ser_im[i] !== sl_im[i]))
                    v_stab[i] <= v_stab[i] + 1;
                if (ram_rd_en[i] && loaded[i] && !ser_done[i]) v_early[i] <= v_early[i] + 1;
                if (frame_done[i]) fd_cnt[i] <= fd_cnt[i] + 1;
                prev_tv[i] <= tx_valid[i];
                prev_wr[i] <= ser_en_wr[i];
                prev_rd[i] <= ser_en_rd[i];
            end
        end
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic outs_or(input int i);
        return ram_rd_en[i] | (|ram_addr[i]) | ser_en_wr[i] | ser_en_rd[i] | (|ser_re[i]) |
               (|ser_im[i]) | (|tx_byte[i]) | tx_valid[i] | busy[i] | frame_done[i];
    endfunction

    function automatic int viol_sum(input int i);
        return v_rdy[i] + v_tv[i] + v_pulse[i] + v_stab[i] + v_early[i];
    endfunction

    function automatic int got_size(input int i);
        return (i == 0) ? got0.size() : got1.size();
    endfunction

    function automatic logic [7:0] got_at(input int i, input int k);
        return (i == 0) ? got0[k] : got1[k];
    endfunction

    task automatic clear_got(input int i);
        if (i == 0) got0.delete();
        else got1.delete();
    endtask

    // Expected frame: header, then per bin re[15:8], im[15:8], re[23:16], im[23:16], then sum mod 256
    task automatic build_exp(input int i);
        logic [7:0]    sum;
        logic [BW-1:0] re, im;
        int            nb;
        nb = (i == 0) ? 4 : 1;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        sum = 8'h00;
        for (int b = 0; b < nb; b++) begin
            re = mem_re[i][b];
            im = mem_im[i][b];
            exp_q.push_back(re[15:8]);
            exp_q.push_back(im[15:8]);
            exp_q.push_back(re[23:16]);
            exp_q.push_back(im[23:16]);
            sum = sum + re[15:8] + im[15:8] + re[23:16] + im[23:16];
        end
        exp_q.push_back(sum);
    endtask

    task automatic pulse_start(input int i);
        @(posedge clk); #1 start[i] = 1'b1;
        @(posedge clk); #1 start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input string tag);
        int cyc;
        cyc = 0;
        while (frame_done[i] !== 1'b1 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check_val({tag, "_done_seen"}, int'(cyc < 5000), 1);
    endtask

    task automatic wait_bytes(input int i, input int n, input string tag);
        int cyc;
        cyc = 0;
        while (got_size(i) < n && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check_val({tag, "_bytes_seen"}, int'(cyc < 5000), 1);
    endtask

    task automatic cmp_frame(input int i, input string tag);
        check_val({tag, "_len"}, got_size(i), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got_size(i); k++)
            check_val($sformatf("%s_b%0d", tag, k), int'(got_at(i, k)), int'(exp_q[k]));
    endtask

    task automatic run_frame(input int i, input string tag);
        int base_fd, base_v;
        build_exp(i);
        clear_got(i);
        base_fd = fd_cnt[i];
        base_v  = viol_sum(i);
        pulse_start(i);
        wait_done(i, tag);
        repeat (6) @(negedge clk);
        cmp_frame(i, tag);
        check_val({tag, "_fdone_cnt"}, fd_cnt[i] - base_fd, 1);
        check_val({tag, "_busy_after"}, int'(busy[i]), 0);
        check_val({tag, "_invariants"}, viol_sum(i) - base_v, 0);
    endtask

    task automatic rand_mem(input int i);
        for (int b = 0; b < 4; b++) begin
            mem_re[i][b] = BW'($urandom);
            mem_im[i][b] = BW'($urandom);
        end
    endtask

    initial begin
        int base_fd, base_v;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0;  inj_en[i] = 1'b0;  force_low[i] = 1'b0;
            drop[i] = 0;  done_dly[i] = 0;
            for (int b = 0; b < 4; b++) begin
                mem_re[i][b] = '0;
                mem_im[i][b] = '0;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_outs_n4", int'(outs_or(0)), 0);
        check_val("rst_outs_n1", int'(outs_or(1)), 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_val("idle_busy", int'(busy[0]), 0);

        // patterned bins, sink always ready
        for (int b = 0; b < 4; b++) begin
            mem_re[0][b] = {8'h00, 4'(b), 16'h1234};
            mem_im[0][b] = {8'h00, 16'hABCD, 4'(b)};
        end
        run_frame(0, "pat_ready");

        // same data, sink drops ready for 10 cycles after each byte
        drop[0] = 10;
        run_frame(0, "pat_drop10");

        // single-bin frame
        mem_re[1][0] = 28'h0FF8000;
        mem_im[1][0] = 28'h0177F00;
        run_frame(1, "n1");
        if (got1.size() == 7) check_val("n1_cksum_const", int'(got1[6]), 8'h15);
        else check_val("n1_cksum_len", got1.size(), 7);

        // stalled sink, spurious serializer strobe in HDR0, start re-pulsed mid-frame
        drop[0] = 1;
        rand_mem(0);
        build_exp(0);
        clear_got(0);
        base_fd = fd_cnt[0];
        base_v  = viol_sum(0);
        force_low[0] = 1'b1;
        pulse_start(0);
        repeat (3) @(posedge clk);
        #1 inj_en[0] = 1'b1;
        @(posedge clk);
        #1 inj_en[0] = 1'b0;
        repeat (20) @(negedge clk);
        check_val("stall_no_tx", got0.size(), 0);
        check_val("stall_busy", int'(busy[0]), 1);
        check_val("stall_no_wr", int'(ser_en_wr[0]), 0);
        @(posedge clk);
        #1 force_low[0] = 1'b0;
        wait_bytes(0, 5, "glitch");
        pulse_start(0);
        wait_done(0, "glitch");
        repeat (40) @(negedge clk);
        cmp_frame(0, "glitch");
        check_val("glitch_fdone_cnt", fd_cnt[0] - base_fd, 1);
        check_val("glitch_busy_after", int'(busy[0]), 0);
        check_val("glitch_invariants", viol_sum(0) - base_v, 0);

        // randomized frames with random sink gaps and serializer done latency
        for (int r = 0; r < 4; r++) begin
            rand_mem(0);
            drop[0] = $urandom_range(1, 10);
            done_dly[0] = $urandom_range(0, 5);
            run_frame(0, $sformatf("rand%0d", r));
        end

        // serializer done held off 5 cycles after the closing advance
        rand_mem(0);
        drop[0] = 3;
        done_dly[0] = 5;
        run_frame(0, "done_dly5");

        // asynchronous reset mid-payload, then a clean frame from bin 0
        rand_mem(0);
        drop[0] = 2;
        done_dly[0] = 1;
        clear_got(0);
        pulse_start(0);
        wait_bytes(0, 7, "midrst");
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("midrst_outs", int'(outs_or(0)), 0);
        check_val("midrst_busy", int'(busy[0]), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_frame(0, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
